pe_conv_scheduler: RTL and testbench

//  Sequencer for the single-PE convolution datapath. On a start pulse it walks every

---
 rtl/pe_conv_scheduler.sv | 152 +++++++++++++++
 tb/tb_pe_conv_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_conv_scheduler.sv
// Window sequencer for the single-PE convolution datapath: walks every valid output
// window, drives operand indices and MAC controls, and hands each result downstream.
module pe_conv_scheduler #(
    parameter int IMG_DIM = 4,
    parameter int KER_DIM = 3,
    parameter int MAC_LAT = 1,
    parameter int IDX_W   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_single,
    input  logic             res_ready,
    output logic             busy,
    output logic [IDX_W-1:0] a_row,
    output logic [IDX_W-1:0] a_col,
    output logic [IDX_W-1:0] b_row,
    output logic [IDX_W-1:0] b_col,
    output logic             mac_clr,
    output logic             mac_en,
    output logic             en_result,
    output logic [IDX_W-1:0] out_row,
    output logic [IDX_W-1:0] out_col,
    output logic             pe_done
);

    localparam int OUT_DIM = IMG_DIM - KER_DIM + 1;
    localparam int LAT_W   = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(KER_DIM - 1);
    localparam logic [IDX_W-1:0] O_LAST   = IDX_W'(OUT_DIM - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_DRAIN,
        S_RESULT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] oy_q, oy_d;
    logic [IDX_W-1:0] ox_q, ox_d;
    logic [IDX_W-1:0] ky_q, ky_d;
    logic [IDX_W-1:0] kx_q, kx_d;
    logic [LAT_W-1:0] lat_q, lat_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            oy_q    <= '0;
            ox_q    <= '0;
            ky_q    <= '0;
            kx_q    <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            oy_q    <= oy_d;
            ox_q    <= ox_d;
            ky_q    <= ky_d;
            kx_q    <= kx_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        oy_d    = oy_q;
        ox_d    = ox_q;
        ky_d    = ky_q;
        kx_d    = kx_q;
        lat_d   = lat_q;
        unique case (state_q)
            S_IDLE: begin
                if (en_single) begin
                    state_d = S_CLEAR;
                    oy_d    = '0;
                    ox_d    = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_MAC;
                ky_d    = '0;
                kx_d    = '0;
            end
            S_MAC: begin
                // Indices stay on the last tap through DRAIN and RESULT.
                if (kx_q == K_LAST && ky_q == K_LAST) begin
                    state_d = S_DRAIN;
                    lat_d   = '0;
                end else if (kx_q == K_LAST) begin
                    kx_d = '0;
                    ky_d = ky_q + 1'b1;
                end else begin
                    kx_d = kx_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (lat_q == LAT_LAST) begin
                    state_d = S_RESULT;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_d = S_CLEAR;
                    if (ox_q == O_LAST) begin
                        ox_d = '0;
                        if (oy_q == O_LAST) begin
                            // Park all counters at zero so IDLE presents zero indices.
                            oy_d    = '0;
                            ky_d    = '0;
                            kx_d    = '0;
                            state_d = S_DONE;
                        end else begin
                            oy_d = oy_q + 1'b1;
                        end
                    end else begin
                        ox_d = ox_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        mac_clr   = (state_q == S_CLEAR);
        mac_en    = (state_q == S_MAC);
        en_result = (state_q == S_RESULT);
        pe_done   = (state_q == S_DONE);
        a_row     = oy_q + ky_q;
        a_col     = ox_q + kx_q;
        b_row     = ky_q;
        b_col     = kx_q;
        out_row   = '0;
        out_col   = '0;
        if (state_q == S_RESULT) begin
            out_row = oy_q;
            out_col = ox_q;
        end
    end

endmodule

// File: tb/tb_pe_conv_scheduler.sv
// Directed bench for pe_conv_scheduler: schedule timing, PE window sums via a behavioural
// accumulator, backpressure, ignored restarts and asynchronous reset mid-run.
module tb_pe_conv_scheduler;

    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en_single = 1'b0;
    logic             res_ready = 1'b0;
    logic             busy;
    logic [IDX_W-1:0] a_row, a_col, b_row, b_col;
    logic             mac_clr, mac_en, en_result, pe_done;
    logic [IDX_W-1:0] out_row, out_col;

    int tests = 0;
    int fails = 0;

    logic [7:0] amat [0:3][0:3];
    logic [7:0] bmat [0:3][0:3];
    logic [7:0] acc;
    logic [16:0] all_o;

    pe_conv_scheduler #(
        .IMG_DIM(4),
        .KER_DIM(3),
        .MAC_LAT(1),
        .IDX_W  (IDX_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en_single(en_single),
        .res_ready(res_ready),
        .busy     (busy),
        .a_row    (a_row),
        .a_col    (a_col),
        .b_row    (b_row),
        .b_col    (b_col),
        .mac_clr  (mac_clr),
        .mac_en   (mac_en),
        .en_result(en_result),
        .out_row  (out_row),
        .out_col  (out_col),
        .pe_done  (pe_done)
    );

    always #5 clk = ~clk;

    assign all_o = {busy, a_row, a_col, b_row, b_col, mac_clr, mac_en,
                    en_result, out_row, out_col, pe_done};

    // Behavioural PE: 8-bit accumulator with one cycle of MAC latency.
    always @(posedge clk or negedge reset) begin
        if (!reset) acc <= '0;
        else if (mac_clr) acc <= '0;
        else if (mac_en) acc <= acc + 8'(amat[a_row][a_col] * bmat[b_row][b_col]);
    end

    function automatic logic [7:0] ref_sum(input int oy, input int ox);
        int s;
        s = 0;
        for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
                s += int'(amat[oy+ky][ox+kx]) * int'(bmat[ky][kx]);
        return 8'(s);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        en_single = 1'b1;
        step();
        en_single = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            en_single = 1'($urandom_range(0, 1));
            res_ready = 1'($urandom_range(0, 1));
            step();
            tests++;
            if (all_o !== '0) begin
                fails++;
                $display("FAIL reset_hold cyc=%0d outputs=%h required=0", i, all_o);
            end
        end
        en_single = 1'b0;
        res_ready = 1'b0;
        reset = 1'b1;
        step();
        tests++;
        if (all_o !== '0) begin
            fails++;
            $display("FAIL reset_release outputs=%h required=0", all_o);
        end
    endtask

    task automatic test_full_run();
        logic [4:0] exp_ctrl;
        logic [1:0] eoy, eox, eky, ekx;
        int w, p, k;
        res_ready = 1'b1;
        start_run();
        for (int n = 1; n <= 52; n++) begin
            exp_ctrl = '0;
            w = (n - 1) / 12;
            p = (n - 1) % 12;
            if (n <= 48) exp_ctrl = {1'b1, p == 0, p >= 1 && p <= 9, p == 11, 1'b0};
            else if (n == 49) exp_ctrl = 5'b10001;
            eoy = 2'(w / 2);
            eox = 2'(w % 2);
            tests++;
            if ({busy, mac_clr, mac_en, en_result, pe_done} !== exp_ctrl) begin
                fails++;
                $display("FAIL run_ctrl cyc=%0d busy/clr/en/res/done=%b required=%b",
                         n, {busy, mac_clr, mac_en, en_result, pe_done}, exp_ctrl);
            end
            if (n <= 48 && p >= 1 && p <= 9) begin
                k = p - 1;
                eky = 2'(k / 3);
                ekx = 2'(k % 3);
                tests++;
                if ({a_row, a_col, b_row, b_col} !== {eoy + eky, eox + ekx, eky, ekx}) begin
                    fails++;
                    $display("FAIL run_idx cyc=%0d a=(%0d,%0d) b=(%0d,%0d) required a=(%0d,%0d) b=(%0d,%0d)",
                             n, a_row, a_col, b_row, b_col, eoy + eky, eox + ekx, eky, ekx);
                end
            end
            if (n <= 48 && p == 11) begin
                tests++;
                if ({out_row, out_col} !== {eoy, eox} || acc !== ref_sum(int'(eoy), int'(eox))) begin
                    fails++;
                    $display("FAIL run_result cyc=%0d out=(%0d,%0d) acc=%0d required out=(%0d,%0d) acc=%0d",
                             n, out_row, out_col, acc, eoy, eox, ref_sum(int'(eoy), int'(eox)));
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int stall, done_at;
        bit released;
        stall = 0;
        done_at = 0;
        released = 1'b0;
        res_ready = 1'b1;
        start_run();
        for (int n = 1; n <= 70; n++) begin
            if (pe_done && done_at == 0) done_at = n;
            if (stall >= 1 && !released) begin
                tests++;
                if ({en_result, mac_en, mac_clr, out_row, out_col} !== 7'b1_0_0_00_01) begin
                    fails++;
                    $display("FAIL bp_hold cyc=%0d res/en/clr/out=%b required=1000001",
                             n, {en_result, mac_en, mac_clr, out_row, out_col});
                end
            end
            if (!released && stall == 0 && en_result && out_row == 2'd0 && out_col == 2'd1) begin
                stall = 1;
                res_ready = 1'b0;
            end else if (stall >= 1 && !released) begin
                if (stall == 5) begin
                    res_ready = 1'b1;
                    released = 1'b1;
                end else begin
                    stall++;
                end
            end
            step();
        end
        tests++;
        if (!released) begin
            fails++;
            $display("FAIL bp_window window (0,1) seen_and_released=%0d required=1", released);
        end
        tests++;
        if (done_at != 54) begin
            fails++;
            $display("FAIL bp_done pe_done cycle=%0d required=54", done_at);
        end
    endtask

    task automatic test_ignore_start();
        int results, dones, done_at;
        results = 0;
        dones = 0;
        done_at = 0;
        res_ready = 1'b1;
        start_run();
        for (int n = 1; n <= 65; n++) begin
            if (en_result && res_ready) results++;
            if (pe_done) begin
                dones++;
                if (done_at == 0) done_at = n;
            end
            en_single = (n == 15);
            step();
        end
        en_single = 1'b0;
        tests++;
        if (results != 4) begin
            fails++;
            $display("FAIL ign_results count=%0d required=4", results);
        end
        tests++;
        if (dones != 1 || done_at != 49) begin
            fails++;
            $display("FAIL ign_done pulses=%0d first=%0d required 1 at 49", dones, done_at);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL ign_idle busy=%b required=0", busy);
        end
    endtask

    task automatic test_async_reset();
        int widx, done_at;
        res_ready = 1'b1;
        start_run();
        for (int n = 1; n < 28; n++) step();
        tests++;
        if ({mac_en, a_row, b_row} !== {1'b1, 2'd1, 2'd0}) begin
            fails++;
            $display("FAIL ar_pre mac_en/a_row/b_row=%b required=10100", {mac_en, a_row, b_row});
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (all_o !== '0) begin
            fails++;
            $display("FAIL ar_immediate outputs=%h required=0", all_o);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (all_o !== '0) begin
                fails++;
                $display("FAIL ar_hold cyc=%0d outputs=%h required=0", i, all_o);
            end
        end
        reset = 1'b1;
        step();
        tests++;
        if ({busy, pe_done} !== 2'b00) begin
            fails++;
            $display("FAIL ar_idle busy/done=%b required=00", {busy, pe_done});
        end
        widx = 0;
        done_at = 0;
        start_run();
        for (int n = 1; n <= 55; n++) begin
            if (en_result) begin
                tests++;
                if (widx > 3 || {out_row, out_col} !== {2'(widx / 2), 2'(widx % 2)}) begin
                    fails++;
                    $display("FAIL ar_order result#%0d out=(%0d,%0d) required=(%0d,%0d)",
                             widx, out_row, out_col, widx / 2, widx % 2);
                end
                widx++;
            end
            if (pe_done && done_at == 0) done_at = n;
            step();
        end
        tests++;
        if (widx != 4 || done_at != 49) begin
            fails++;
            $display("FAIL ar_restart results=%0d done_cycle=%0d required 4 and 49", widx, done_at);
        end
    endtask

    initial begin
        logic [7:0] avals [16];
        logic [7:0] bvals [9];
        avals = '{8'd233, 8'd17, 8'd45, 8'd90, 8'd12, 8'd200, 8'd8, 8'd66,
                  8'd150, 8'd3, 8'd99, 8'd41, 8'd7, 8'd128, 8'd64, 8'd27};
        bvals = '{8'd13, 8'd9, 8'd5, 8'd2, 8'd11, 8'd7, 8'd4, 8'd3, 8'd1};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                amat[r][c] = avals[r*4+c];
                bmat[r][c] = (r < 3 && c < 3) ? bvals[r*3+c] : 8'd0;
            end
        #1;
        test_reset();
        test_full_run();
        test_backpressure();
        test_ignore_start();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
